// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / redirect controller for a 5-stage in-order core.
//
// Purpose:
//   Combines the data-bus wait, a multi-cycle divider, EX-stage jumps and
//   load-use hazards into per-stage hold / flush enables and a PC redirect.
//   All hold/flush/jump outputs are combinational so the pipeline registers
//   see them in the same cycle the condition appears. A jump that arrives while
//   the bus is stalled is parked in pend_addr and issued once the bus frees up.
//
// Ports:
//   clk_100MHz     in   1  system clock, rising edge
//   arst_n         in   1  asynchronous active-low reset
//   jump_req_i     in   1  EX taken branch/jump, one-cycle pulse
//   jump_addr_i    in  32  jump target, qualified by jump_req_i
//   ex_load_i      in   1  EX instruction is a load
//   ex_rd_i        in   5  EX destination register
//   id_rs1_i       in   5  ID source register 1
//   id_rs2_i       in   5  ID source register 2
//   div_start_i    in   1  divide launched in EX, one-cycle pulse
//   div_done_i     in   1  divider result valid, one-cycle pulse
//   bus_wait_i     in   1  data bus not ready (level)
//   hold_pc_o      out  1  hold program counter
//   hold_if_id_o   out  1  hold IF/ID register
//   hold_id_ex_o   out  1  hold ID/EX register
//   flush_if_id_o  out  1  bubble into IF/ID
//   flush_id_ex_o  out  1  bubble into ID/EX
//   jump_ena_o     out  1  PC redirect strobe
//   jump_addr_o    out 32  redirect target (0 when jump_ena_o=0)
//   state_o        out  2  FSM state: 0 IDLE, 1 DIV, 2 JPEND
//   stall_cnt_o    out 16  saturating count of edges with hold_pc_o=1

module pipe_ctrl (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        div_start_i,
  input  logic        div_done_i,
  input  logic        bus_wait_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_ena_o,
  output logic [31:0] jump_addr_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV     = 2'd1,
    JPEND   = 2'd2,
    INVALID = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pend_addr_reg;
  logic [15:0] stall_cnt_reg;

  logic load_use;

  // r0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_load_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  // Output decode, highest priority first: bus wait, divide, pending jump,
  // live jump, load-use. A jump in the same cycle as a load-use hazard wins:
  // the dependent ID instruction is on the wrong path and gets flushed anyway.
  always_comb begin
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_ena_o    = 1'b0;
    jump_addr_o   = 32'd0;
    if (bus_wait_i) begin
      hold_pc_o    = 1'b1;
      hold_if_id_o = 1'b1;
      hold_id_ex_o = 1'b1;
    end else if (state_reg == DIV) begin
      // The done cycle releases the pipeline immediately.
      if (!div_done_i) begin
        hold_pc_o    = 1'b1;
        hold_if_id_o = 1'b1;
        hold_id_ex_o = 1'b1;
      end
    end else if (state_reg == JPEND) begin
      jump_ena_o    = 1'b1;
      jump_addr_o   = pend_addr_reg;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (jump_req_i) begin
      jump_ena_o    = 1'b1;
      jump_addr_o   = jump_addr_i;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (load_use) begin
      // Freeze PC and IF/ID, let ID/EX take a bubble.
      hold_pc_o     = 1'b1;
      hold_if_id_o  = 1'b1;
      flush_id_ex_o = 1'b1;
    end
  end

  // Control FSM plus pending-jump address and stall counter.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_reg     <= IDLE;
      pend_addr_reg <= 32'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      if (hold_pc_o && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      case (state_reg)
        IDLE: begin
          // A jump that cannot redirect now (bus stalled) is parked.
          if (jump_req_i && bus_wait_i) begin
            pend_addr_reg <= jump_addr_i;
            state_reg     <= JPEND;
          end else if (div_start_i) begin
            state_reg <= DIV;
          end
        end
        DIV: begin
          if (div_done_i) begin
            state_reg <= IDLE;
          end
        end
        JPEND: begin
          // A newer jump supersedes the parked one.
          if (jump_req_i) begin
            pend_addr_reg <= jump_addr_i;
          end
          // The redirect is driven combinationally in the first non-wait
          // cycle, so leave right after it.
          if (!bus_wait_i) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign state_o     = state_reg;
  assign stall_cnt_o = stall_cnt_reg;

endmodule
